// File: rtl/bp_ctr_table_if.sv
// bp_ctr_table_if -- port bundle for the branch-predictor counter table.
//
// Signals
//   clear_i      synchronous re-initialise request
//   rd_addr_i    NUM_RD packed lookup indices, port p = [p*INDEX +: INDEX]
//   rd_ctr_o     NUM_RD packed counters,       port p = [p*CTR_W +: CTR_W]
//   upd_valid_i  update request qualifier
//   upd_addr_i   update index
//   upd_taken_i  resolved direction (1 = increment, 0 = decrement)
//   ready_o      init sweep complete, table usable
//   dbg_state_o  controller state (0 = INIT, 1 = READY)
//
// Handshake: the update port is valid-only. An update is accepted on every
// rising edge where upd_valid_i=1 and ready_o=1; there is no backpressure.
// While ready_o=0 an asserted upd_valid_i is dropped, not queued.
//
// Modports: master drives requests (fetch/commit side), slave is the table.
interface bp_ctr_table_if #(
  parameter int INDEX  = 10,
  parameter int CTR_W  = 2,
  parameter int NUM_RD = 4
);
  logic                      clear_i;
  logic [NUM_RD*INDEX-1:0]   rd_addr_i;
  logic [NUM_RD*CTR_W-1:0]   rd_ctr_o;
  logic                      upd_valid_i;
  logic [INDEX-1:0]          upd_addr_i;
  logic                      upd_taken_i;
  logic                      ready_o;
  logic                      dbg_state_o;

  modport master (
    output clear_i, rd_addr_i, upd_valid_i, upd_addr_i, upd_taken_i,
    input  rd_ctr_o, ready_o, dbg_state_o
  );

  modport slave (
    input  clear_i, rd_addr_i, upd_valid_i, upd_addr_i, upd_taken_i,
    output rd_ctr_o, ready_o, dbg_state_o
  );
endinterface

// File: rtl/bp_ctr_table.sv
// bp_ctr_table -- saturating-counter table for the fetch-stage predictor.
//
// NUM_RD combinational lookup ports and one update port. An update carries a
// resolved direction; the table applies a saturating +/-1 through a 2-stage
// read-modify-write pipe (S1: request, S2: old value + new value). Back-to-back
// updates to one index forward S2's new value into S1 so no step is lost.
// After reset or clear_i the array is filled with INIT_VAL by a one-entry-per-
// cycle sweep; ready_o rises when the sweep completes.
//
// Ports
//   clk    clock, all state on posedge
//   reset  asynchronous, active-high
//   bus    bp_ctr_table_if.slave (lookup, update, clear, ready, debug state)
//
// Build option
//   BP_CTR_BYPASS_EN  when defined, a lookup matching the valid S2 entry returns
//                     the value being written this cycle (write-through).
//                     When undefined, lookups see array contents only.
module bp_ctr_table #(
  parameter int DEPTH    = 1024,
  parameter int INDEX    = 10,
  parameter int CTR_W    = 2,
  parameter int NUM_RD   = 4,
  parameter int INIT_VAL = 2
) (
  input  logic         clk,
  input  logic         reset,
  bp_ctr_table_if.slave bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);
  localparam logic [CTR_W-1:0] INIT_C   = CTR_W'(INIT_VAL);

  logic [CTR_W-1:0] ram [DEPTH];

  state_t           state;
  logic [INDEX-1:0] ptr;
  logic             ready_q;

  logic             s1_valid;
  logic [INDEX-1:0] s1_addr;
  logic             s1_taken;
  logic             s2_valid;
  logic [INDEX-1:0] s2_addr;
  logic             s2_taken;
  logic [CTR_W-1:0] s2_old;
  logic [CTR_W-1:0] s2_new;
  logic [CTR_W-1:0] s1_old;
  logic [NUM_RD*CTR_W-1:0] rd_ctr;

  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] old,
                                                 input logic taken);
    if (taken) return (old == {CTR_W{1'b1}}) ? old : old + CTR_W'(1);
    else       return (old == '0)            ? old : old - CTR_W'(1);
  endfunction

  assign s2_new = sat_step(s2_old, s2_taken);

  // Forward the in-flight result when S1 targets the index S2 is writing this
  // cycle; the array still holds the pre-update value at that point.
  assign s1_old = (s2_valid && (s2_addr == s1_addr)) ? s2_new : ram[s1_addr];

  // Control: FSM, sweep pointer, pipe valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      ptr      <= '0;
      ready_q  <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= ready_q & bus.upd_valid_i;
      s2_valid <= s1_valid;
      case (state)
        ST_INIT: begin
          if (bus.clear_i) begin
            ptr <= '0;
          end else begin
            ptr <= ptr + INDEX'(1);
            if (ptr == LAST_IDX) begin
              state   <= ST_READY;
              ready_q <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (bus.clear_i) begin
            state   <= ST_INIT;
            ptr     <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          ptr     <= '0;
          ready_q <= 1'b0;
        end
      endcase
      // Clear drops anything in flight.
      if (bus.clear_i) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end
    end
  end

  // Datapath and array: no reset, qualified by the valids above.
  // The sweep and the update write never overlap because they are split by state.
  always_ff @(posedge clk) begin
    s1_addr  <= bus.upd_addr_i;
    s1_taken <= bus.upd_taken_i;
    s2_addr  <= s1_addr;
    s2_taken <= s1_taken;
    s2_old   <= s1_old;
    if (state == ST_INIT) begin
      ram[ptr] <= INIT_C;
    end else if (s2_valid) begin
      ram[s2_addr] <= s2_new;
    end
  end

  always_comb begin
    rd_ctr = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (!ready_q) begin
        rd_ctr[p*CTR_W +: CTR_W] = INIT_C;
      end else begin
        rd_ctr[p*CTR_W +: CTR_W] = ram[bus.rd_addr_i[p*INDEX +: INDEX]];
`ifdef BP_CTR_BYPASS_EN
        if (s2_valid && (s2_addr == bus.rd_addr_i[p*INDEX +: INDEX]))
          rd_ctr[p*CTR_W +: CTR_W] = s2_new;
`endif
      end
    end
  end

  assign bus.rd_ctr_o    = rd_ctr;
  assign bus.ready_o     = ready_q;
  assign bus.dbg_state_o = state;

endmodule

// File: tb/tb_bp_ctr_table.sv
// tb_bp_ctr_table -- directed bench for bp_ctr_table.
// Stimulus tasks push the expected {dbg_state, ready_o, rd_ctr_o} into exp_q and
// raise chk_req for that cycle; the monitor pops and compares on the falling edge.
module tb_bp_ctr_table;
  localparam int DEPTH  = 1024;
  localparam int INDEX  = 10;
  localparam int CTR_W  = 2;
  localparam int NUM_RD = 4;
  localparam int W      = 2 + NUM_RD*CTR_W;
`ifdef BP_CTR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_ctr_table_if #(.INDEX(INDEX), .CTR_W(CTR_W), .NUM_RD(NUM_RD)) bus();

  bp_ctr_table #(
    .DEPTH(DEPTH), .INDEX(INDEX), .CTR_W(CTR_W), .NUM_RD(NUM_RD), .INIT_VAL(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_req = 1'b0;
  int           n_vec   = 0;
  int           n_fail  = 0;

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge and idle the pulsed inputs.
  task automatic step();
    @(posedge clk);
    #1;
    chk_req         = 1'b0;
    bus.upd_valid_i = 1'b0;
    bus.clear_i     = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [INDEX-1:0] a3, a2, a1, a0);
    bus.rd_addr_i = {a3, a2, a1, a0};
  endtask

  task automatic upd(input logic [INDEX-1:0] a, input logic taken);
    bus.upd_valid_i = 1'b1;
    bus.upd_addr_i  = a;
    bus.upd_taken_i = taken;
  endtask

  task automatic expect_out(input string nm, input logic rdy,
                            input logic [CTR_W-1:0] c3, c2, c1, c0);
    exp_q.push_back({rdy, rdy, c3, c2, c1, c0});
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  function automatic logic [CTR_W-1:0] pick(input bit sel,
                                            input logic [CTR_W-1:0] a, b);
    return sel ? a : b;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    string        nm;
    if (chk_req) begin
      got = {bus.dbg_state_o, bus.ready_o, bus.rd_ctr_o};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL no_expected: got %h, nothing queued", got);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", nm, got, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [CTR_W-1:0] bt;
  initial begin
    bus.clear_i     = 1'b0;
    bus.upd_valid_i = 1'b0;
    bus.upd_addr_i  = '0;
    bus.upd_taken_i = 1'b0;
    bus.rd_addr_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Init sweep timing after reset
    rd(1, 2, 3, 4);
    expect_out("reset_state", 0, 2, 2, 2, 2);
    steps(DEPTH-1);
    expect_out("init_hold", 0, 2, 2, 2, 2);
    step();
    rd(1023, 0, 1023, 0);
    expect_out("init_done", 1, 2, 2, 2, 2);

    // Four taken updates to idx 5: 2->3 then saturated
    step(); upd(5, 1); rd(5, 5, 5, 5);
    step(); upd(5, 1);
    step(); upd(5, 1);
    bt = pick(BYP, 3, 2);
    expect_out("taken_c2", 1, bt, bt, bt, bt);
    step(); upd(5, 1);
    expect_out("taken_c3", 1, 3, 3, 3, 3);
    steps(3);
    rd(4, 5, 6, 5);
    expect_out("taken_final", 1, 2, 3, 2, 3);

    // Three not-taken updates to idx 7: 2->1->0->0
    step(); upd(7, 0); rd(7, 7, 7, 7);
    step(); upd(7, 0);
    step(); upd(7, 0);
    bt = pick(BYP, 1, 2);
    expect_out("ntaken_c2", 1, bt, bt, bt, bt);
    step();
    bt = pick(BYP, 0, 1);
    expect_out("ntaken_c3", 1, bt, bt, bt, bt);
    step();
    expect_out("ntaken_c4", 1, 0, 0, 0, 0);
    step();
    expect_out("ntaken_c5", 1, 0, 0, 0, 0);

    // Interleave idx 7 (taken, 0->2) and idx 8 (not taken, 2->0)
    step(); upd(7, 1);
    step(); upd(8, 0);
    step(); upd(7, 1);
    step(); upd(8, 0);
    steps(3);
    rd(8, 7, 8, 7);
    expect_out("interleave", 1, 0, 2, 0, 2);

    // Lookup of an in-flight update to idx 9
    step(); upd(9, 1); rd(9, 9, 9, 9);
    step();
    step();
    bt = pick(BYP, 3, 2);
    expect_out("bypass_c2", 1, bt, bt, bt, bt);
    step();
    expect_out("bypass_c3", 1, 3, 3, 3, 3);

    // Update idx 3, clear one cycle later: update dropped, table re-swept
    step(); upd(3, 1); rd(3, 5, 3, 5);
    step(); bus.clear_i = 1'b1;
    step(); upd(3, 1);
    expect_out("clear_sweep_start", 0, 2, 2, 2, 2);
    steps(498); upd(3, 1);
    expect_out("clear_sweep_mid", 0, 2, 2, 2, 2);
    steps(DEPTH-1-498);
    expect_out("clear_sweep_end", 0, 2, 2, 2, 2);
    step();
    rd(3, 5, 9, 7);
    expect_out("clear_done", 1, 2, 2, 2, 2);

    // Async reset while ready, then again mid-sweep (ptr = 500)
    step(); reset = 1'b1;
    expect_out("reset_async_ready", 0, 2, 2, 2, 2);
    step(); reset = 1'b0;
    steps(500); reset = 1'b1;
    expect_out("reset_async_sweep", 0, 2, 2, 2, 2);
    step(); reset = 1'b0;
    rd(0, 1023, 3, 5);
    steps(DEPTH-1);
    expect_out("resweep_hold", 0, 2, 2, 2, 2);
    step();
    expect_out("resweep_done", 1, 2, 2, 2, 2);

    steps(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
